// File: rtl/player_input_pkg.sv
// Shared constants for the tug-of-war lab, so the play field bench and the board top
// agree on the input-stage timing.
package player_input_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  // Counter must hold 0..DEBOUNCE_CYCLES without wrapping.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/player_input_if.sv
// Player button bundle: raw buttons and enable in, move pulses and debounced levels out.
interface player_input_if;

  logic rawL;
  logic rawR;
  logic enable;
  logic L;
  logic R;
  logic levelL;
  logic levelR;

  modport master (
    output rawL,
    output rawR,
    output enable,
    input  L,
    input  R,
    input  levelL,
    input  levelR
  );

  modport slave (
    input  rawL,
    input  rawR,
    input  enable,
    output L,
    output R,
    output levelL,
    output levelR
  );

endinterface

// File: rtl/press_pulse.sv
// One button channel: synchroniser, stable-sample debounce, then an enable-gated
// rising-edge one-shot.
module press_pulse
  import player_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  input  logic enable,
  output logic pulse,
  output logic level
);

  localparam int unsigned CntW = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any sample agreeing with the current level restarts the acceptance window.
    if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Only a rise seen while enabled moves; a rise while disabled is consumed.
    pulse_d = level_d & ~level_q & enable;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/player_input.sv
// Upstream input stage for the tug-of-war play field: two independent button channels
// producing single-cycle L and R move pulses.
module player_input
  import player_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic           Clock,
  input logic           Reset,
  player_input_if.slave bus
);

  // Simultaneous presses pass straight through; the play field resolves them.
  press_pulse #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.rawL),
    .enable(bus.enable),
    .pulse (bus.L),
    .level (bus.levelL)
  );

  press_pulse #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.rawR),
    .enable(bus.enable),
    .pulse (bus.R),
    .level (bus.levelR)
  );

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with default timing (press pulses 6 edges after raw rise).
module tb_player_input;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  player_input_if pif ();

  player_input dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (pif)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if ({pif.L, pif.R, pif.levelL, pif.levelR} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: L R levelL levelR = %b expected 0000",
                 {pif.L, pif.R, pif.levelL, pif.levelR});
      end
    end
    Reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if ({pif.L, pif.R, pif.levelL, pif.levelR} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: outputs = %b expected 0000", i,
                 {pif.L, pif.R, pif.levelL, pif.levelR});
      end
    end
  endtask

  // Partial count discarded by reset, held buttons re-accepted, then async clear.
  task automatic test_reset_mid;
    pif.rawL = 1'b1;
    pif.rawR = 1'b1;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if ({pif.L, pif.R} !== {2{i == 6}}) begin
        errors++;
        $display("FAIL reset_fresh_press cyc %0d: L R = %b expected %b", i, {pif.L, pif.R},
                 {2{i == 6}});
      end
    end
    #1;
    Reset = 1'b1;
    #1;
    checks++;
    if ({pif.L, pif.R, pif.levelL, pif.levelR} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: outputs = %b expected 0000",
               {pif.L, pif.R, pif.levelL, pif.levelR});
    end
    tick();
    Reset    = 1'b0;
    pif.rawL = 1'b0;
    pif.rawR = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_press_hold;
    pif.rawL = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (pif.L !== (i == 6)) begin
        errors++;
        $display("FAIL hold_L cyc %0d: L = %b expected %b", i, pif.L, i == 6);
      end
      checks++;
      if (pif.levelL !== (i >= 6)) begin
        errors++;
        $display("FAIL hold_levelL cyc %0d: levelL = %b expected %b", i, pif.levelL, i >= 6);
      end
      checks++;
      if ({pif.R, pif.levelR} !== 2'b00) begin
        errors++;
        $display("FAIL hold_R_quiet cyc %0d: R levelR = %b expected 00", i, {pif.R, pif.levelR});
      end
    end
    pif.rawL = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (pif.L !== 1'b0) begin
        errors++;
        $display("FAIL release_L cyc %0d: L = %b expected 0", i, pif.L);
      end
    end
    checks++;
    if (pif.levelL !== 1'b0) begin
      errors++;
      $display("FAIL release_levelL: levelL = %b expected 0", pif.levelL);
    end
  endtask

  task automatic test_glitch;
    pif.rawR = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 3) pif.rawR = 1'b0;
      checks++;
      if ({pif.R, pif.levelR} !== 2'b00) begin
        errors++;
        $display("FAIL glitch_R cyc %0d: R levelR = %b expected 00", i, {pif.R, pif.levelR});
      end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] pattern;
    pattern = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      pif.rawL = pattern[3-i];
      tick();
      checks++;
      if (pif.L !== 1'b0) begin
        errors++;
        $display("FAIL bounce_L step %0d: L = %b expected 0", i, pif.L);
      end
    end
    pif.rawL = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (pif.L !== (i == 6)) begin
        errors++;
        $display("FAIL bounce_settle cyc %0d: L = %b expected %b", i, pif.L, i == 6);
      end
    end
    pif.rawL = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous;
    for (int round = 0; round < 2; round++) begin
      pif.rawL = 1'b1;
      pif.rawR = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        checks++;
        if ({pif.L, pif.R} !== {2{i == 6}}) begin
          errors++;
          $display("FAIL simul round %0d cyc %0d: L R = %b expected %b", round, i,
                   {pif.L, pif.R}, {2{i == 6}});
        end
      end
      pif.rawL = 1'b0;
      pif.rawR = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        checks++;
        if ({pif.L, pif.R} !== 2'b00) begin
          errors++;
          $display("FAIL simul_release round %0d cyc %0d: L R = %b expected 00", round, i,
                   {pif.L, pif.R});
        end
      end
    end
  endtask

  task automatic test_enable;
    pif.enable = 1'b0;
    pif.rawL   = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (pif.L !== 1'b0) begin
        errors++;
        $display("FAIL disabled_L cyc %0d: L = %b expected 0", i, pif.L);
      end
    end
    checks++;
    if (pif.levelL !== 1'b1) begin
      errors++;
      $display("FAIL disabled_levelL: levelL = %b expected 1", pif.levelL);
    end
    pif.enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (pif.L !== 1'b0) begin
        errors++;
        $display("FAIL enable_midhold cyc %0d: L = %b expected 0", i, pif.L);
      end
    end
    pif.rawL = 1'b0;
    repeat (10) tick();
    pif.rawL = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (pif.L !== (i == 6)) begin
        errors++;
        $display("FAIL enable_repress cyc %0d: L = %b expected %b", i, pif.L, i == 6);
      end
    end
    pif.rawL = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Reset      = 1'b1;
    pif.rawL   = 1'b0;
    pif.rawR   = 1'b0;
    pif.enable = 1'b1;
    test_reset();
    test_reset_mid();
    test_press_hold();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_input.md
Name: player_input

Overview:
- Upstream input stage for the tug-of-war play field. Conditions the two raw player buttons into the single-cycle L and R move pulses the play field consumes.
- Each channel passes through a synchroniser, then a stable-sample debounce filter, then a rising-edge one-shot.
- A held button yields exactly one move. Releases and bounces yield none.
- An enable input freezes play once a winner is declared.

Parameters:
- SYNC_STAGES, 2: flip-flops in each synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 4: consecutive clock edges a new synchronised level must persist before it is accepted; minimum 1. Sized for simulation; the board build overrides it, e.g. 500000.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- rawL  input  1  left player button, asynchronous, active-high (already inverted from KEY).
- rawR  input  1  right player button, asynchronous, active-high.
- enable  input  1  1 = moves allowed; 0 = suppress L/R pulses (game over or paused).
- L  output  1  one-cycle pulse, one per accepted left press.
- R  output  1  one-cycle pulse, one per accepted right press.
- levelL  output  1  debounced left button level (status/LED).
- levelR  output  1  debounced right button level.

Behaviour:
- Reset (async, active-high): all synchroniser flops, counters, levels and pulse registers go to 0. L=R=levelL=levelR=0 while Reset is high and until the first accepted press.
- The two channels are fully independent and identical.
- Synchroniser: raw input shifts through SYNC_STAGES flops. sync_out is the last stage.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - On each edge where sync_out == level, the counter clears to 0.
  - Where sync_out != level and counter == DEBOUNCE_CYCLES-1: level toggles and the counter clears.
  - Otherwise the counter increments.
  - The counter never wraps.
- Pulse: registered. pulse_next = (level_next & ~level) & enable, so the pulse is high for exactly one cycle, aligned with the rising of level.
- Falling of level (release) never produces a pulse.
- Latency: raw rises before edge 1 and stays stable. Pulse is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 with defaults), then low from the next edge.
- Glitch rejection: any raw high shorter than DEBOUNCE_CYCLES synchronised samples leaves level and outputs at 0.
- Bounce during acceptance: any sample that agrees with the current level restarts the count from 0.
- Held button: one pulse only. A new pulse requires a debounced release followed by a debounced press.
- Enable:
  - Gates only the pulses. Synchroniser and debounce logic keep running.
  - A press whose level rises while enable=0 is consumed silently. Raising enable while the button is held produces no pulse.
- Simultaneous presses: L and R may pulse in the same cycle. Both are passed through; resolving them is the play field's rule.
- Reset mid-operation: a partial count is discarded. A button still held when Reset falls is treated as a fresh press and pulses after the full latency.

Decomposition:
- Shared package: no new package needed. SYNC_STAGES and DEBOUNCE_CYCLES defaults go in the lab's existing shared constants package so the play field bench and the board top agree.
- Sub-module: press_pulse handles one channel (sync, debounce, one-shot, enable gating).
- player_input instantiates press_pulse twice, once for L and once for R.

Test Plan:
- Reset=1 then 0, rawL=rawR=0 for 10 cycles -> L=R=levelL=levelR=0 throughout; assert Reset mid-count -> all outputs 0 at once.
- enable=1, rawL rises and is held 20 cycles -> L=1 for exactly the one cycle after edge 6; levelL=1 from that cycle onward; R stays 0.
- rawR high for 3 cycles then low (glitch shorter than DEBOUNCE_CYCLES) -> R=0 and levelR=0 throughout.
- rawL toggles 1,0,1,0 on successive cycles, then held high -> exactly one L pulse, 6 edges after the final rise.
- rawL and rawR rise on the same cycle and are held -> L=1 and R=1 in the same single cycle; after release and re-press, one more pulse on each.
- enable=0, press and hold rawL, raise enable mid-hold, release, press again -> no pulse for the first press; one L pulse for the second press.
